// File: rtl/lockstep_checker.sv
// Lockstep comparator: per-channel DUT/model compare, time-stamped mismatch log, PASS/FAIL run control.
// Optional build macro LOCKSTEP_STOP_ON_ERR_EN: fail on the first mismatch instead of running to halt.

module lockstep_lane #(
   parameter int WIDTH = 16
) (
   input  logic             en,
   input  logic [WIDTH-1:0] dut_val,
   input  logic [WIDTH-1:0] exp_val,
   output logic             mis
);
   assign mis = en && (dut_val != exp_val);
endmodule

module lockstep_checker #(
   parameter int NUM_CH    = 5,
   parameter int WIDTH     = 16,
   parameter int LOG_DEPTH = 8,
   parameter int DRAIN_CYC = 4,
   parameter int TIMEOUT   = 1000000,
   localparam int CHW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    stall,
   input  logic [NUM_CH-1:0]       ch_valid,
   input  logic [NUM_CH*WIDTH-1:0] dut_data,
   input  logic [NUM_CH*WIDTH-1:0] exp_data,
   input  logic                    hlt,
   input  logic                    exp_hlt,
   input  logic                    log_rd,
   output logic                    log_valid,
   output logic [CHW-1:0]          log_ch,
   output logic [31:0]             log_cycle,
   output logic [WIDTH-1:0]        log_dut,
   output logic [WIDTH-1:0]        log_exp,
   output logic                    log_ovf,
   output logic [NUM_CH-1:0]       err_mask,
   output logic                    hlt_err,
   output logic                    timeout,
   output logic                    done,
   output logic                    pass
);
   localparam int AW  = $clog2(LOG_DEPTH);
   localparam int DCW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
   localparam logic [AW:0] PTR_ONE = 1;

   typedef enum logic [1:0] {RUN, DRAIN, PASS, FAIL} state_t;

   typedef struct packed {
      logic [CHW-1:0]   ch;
      logic [31:0]      stamp;
      logic [WIDTH-1:0] dut_val;
      logic [WIDTH-1:0] exp_val;
   } entry_t;

   state_t                       state;
   logic [31:0]                  cycle;
   logic [DCW-1:0]               drain_cnt;
   logic [NUM_CH-1:0][WIDTH-1:0] dut_v, exp_v;
   logic [NUM_CH-1:0]            mis;
   logic                         running, active, any_mis;
   logic [CHW-1:0]               first_ch;
   entry_t                       mem [LOG_DEPTH];
   entry_t                       head;
   logic [AW:0]                  wr_ptr, rd_ptr;
   logic                         empty, full, pop, push, drop;

   assign dut_v   = dut_data;
   assign exp_v   = exp_data;
   assign running = (state == RUN) || (state == DRAIN);
   assign active  = running && !stall;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
      lockstep_lane #(.WIDTH(WIDTH)) u_lane (
         .en      (active && ch_valid[i]),
         .dut_val (dut_v[i]),
         .exp_val (exp_v[i]),
         .mis     (mis[i])
      );
   end

   // descending scan so the lowest mismatching channel wins
   always_comb begin
      first_ch = '0;
      for (int i = NUM_CH - 1; i >= 0; i--)
         if (mis[i]) first_ch = CHW'(i);
   end
   assign any_mis = |mis;

   // a pop in the same cycle frees the slot, so a full log can still accept
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign pop   = log_rd && !empty;
   assign push  = any_mis && (!full || pop);
   assign drop  = any_mis && full && !pop;

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr[AW-1:0]] <= '{ch: first_ch, stamp: cycle,
                                  dut_val: dut_v[first_ch], exp_val: exp_v[first_ch]};
   end

   always_comb begin
      head = '0;
      if (!empty) head = mem[rd_ptr[AW-1:0]];
   end

   assign log_valid = !empty;
   assign log_ch    = head.ch;
   assign log_cycle = head.stamp;
   assign log_dut   = head.dut_val;
   assign log_exp   = head.exp_val;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RUN;
         cycle     <= '0;
         drain_cnt <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         log_ovf   <= 1'b0;
         err_mask  <= '0;
         hlt_err   <= 1'b0;
         timeout   <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
      end else begin
         if (pop)  rd_ptr  <= rd_ptr + PTR_ONE;
         if (push) wr_ptr  <= wr_ptr + PTR_ONE;
         if (drop) log_ovf <= 1'b1;
         err_mask <= err_mask | mis;
         if (running && cycle != '1) cycle <= cycle + 32'd1;

         case (state)
            RUN: begin
               if (hlt != exp_hlt) begin
                  state   <= FAIL;
                  hlt_err <= 1'b1;
                  done    <= 1'b1;
               end else if (cycle == 32'(TIMEOUT - 1)) begin
                  state   <= FAIL;
                  timeout <= 1'b1;
                  done    <= 1'b1;
               end else
`ifdef LOCKSTEP_STOP_ON_ERR_EN
               if (any_mis) begin
                  state <= FAIL;
                  done  <= 1'b1;
               end else
`endif
               if (hlt && exp_hlt) begin
                  state     <= DRAIN;
                  drain_cnt <= DCW'(DRAIN_CYC - 1);
               end
            end
            DRAIN: begin
`ifdef LOCKSTEP_STOP_ON_ERR_EN
               if (any_mis) begin
                  state <= FAIL;
                  done  <= 1'b1;
               end else
`endif
               if (drain_cnt == '0) begin
                  done <= 1'b1;
                  // include this cycle's mismatches, not yet visible in err_mask
                  if (err_mask == '0 && !any_mis) begin
                     state <= PASS;
                     pass  <= 1'b1;
                  end else begin
                     state <= FAIL;
                  end
               end else begin
                  drain_cnt <= drain_cnt - DCW'(1);
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_lockstep_checker.sv
// Randomized and directed bench for lockstep_checker against a queue-based behavioural model.
module tb_lockstep_checker;
   localparam int NUM_CH    = 5;
   localparam int WIDTH     = 16;
   localparam int LOG_DEPTH = 8;
   localparam int DRAIN_CYC = 4;
   localparam int TIMEOUT   = 50;
   localparam int CHW       = 3;
   localparam int DW        = NUM_CH * WIDTH;

   logic              clk = 1'b0, rst = 1'b1, stall = 1'b0;
   logic              hlt = 1'b0, exp_hlt = 1'b0, log_rd = 1'b0;
   logic [NUM_CH-1:0] ch_valid = '0;
   logic [DW-1:0]     dut_data = '0, exp_data = '0;
   logic              log_valid, log_ovf, hlt_err, timeout, done, pass;
   logic [CHW-1:0]    log_ch;
   logic [31:0]       log_cycle;
   logic [WIDTH-1:0]  log_dut, log_exp;
   logic [NUM_CH-1:0] err_mask;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   lockstep_checker #(
      .NUM_CH(NUM_CH), .WIDTH(WIDTH), .LOG_DEPTH(LOG_DEPTH),
      .DRAIN_CYC(DRAIN_CYC), .TIMEOUT(TIMEOUT)
   ) u_dut (
      .clk(clk), .rst(rst), .stall(stall), .ch_valid(ch_valid),
      .dut_data(dut_data), .exp_data(exp_data), .hlt(hlt), .exp_hlt(exp_hlt),
      .log_rd(log_rd), .log_valid(log_valid), .log_ch(log_ch), .log_cycle(log_cycle),
      .log_dut(log_dut), .log_exp(log_exp), .log_ovf(log_ovf), .err_mask(err_mask),
      .hlt_err(hlt_err), .timeout(timeout), .done(done), .pass(pass)
   );

   // ---------------- reference model ----------------
   typedef struct {
      int               ch;
      int               cyc;
      logic [WIDTH-1:0] d;
      logic [WIDTH-1:0] e;
   } ent_t;

   ent_t              mq[$];
   int                m_cyc, m_drain;   // m_drain < 0 : still running, not yet halted
   bit                m_fin, m_pass, m_ovf, m_herr, m_tmo;
   logic [NUM_CH-1:0] m_err;

   task automatic model_reset();
      mq.delete();
      m_cyc = 0; m_drain = -1;
      m_fin = 0; m_pass = 0; m_ovf = 0; m_herr = 0; m_tmo = 0;
      m_err = '0;
   endtask

   task automatic model_step(input logic st, input logic [NUM_CH-1:0] v,
                             input logic [DW-1:0] d, input logic [DW-1:0] e,
                             input logic h, input logic eh, input logic rd);
      logic [NUM_CH-1:0] hit;
      int first;
      hit = '0;
      first = -1;
      if (!m_fin && !st)
         for (int i = 0; i < NUM_CH; i++)
            if (v[i] && d[i*WIDTH +: WIDTH] != e[i*WIDTH +: WIDTH]) begin
               hit[i] = 1'b1;
               if (first < 0) first = i;
            end
      if (rd && mq.size() > 0) void'(mq.pop_front());
      if (first >= 0) begin
         if (mq.size() < LOG_DEPTH)
            mq.push_back('{first, m_cyc, d[first*WIDTH +: WIDTH], e[first*WIDTH +: WIDTH]});
         else
            m_ovf = 1;
      end
      if (!m_fin) begin
         if (m_drain < 0) begin
            if (h != eh) begin m_herr = 1; m_fin = 1; end
            else if (m_cyc == TIMEOUT - 1) begin m_tmo = 1; m_fin = 1; end
`ifdef LOCKSTEP_STOP_ON_ERR_EN
            else if (hit != 0) m_fin = 1;
`endif
            else if (h && eh) m_drain = DRAIN_CYC - 1;
         end else begin
`ifdef LOCKSTEP_STOP_ON_ERR_EN
            if (hit != 0) m_fin = 1;
            else
`endif
            if (m_drain == 0) begin
               m_fin = 1;
               m_pass = ((m_err | hit) == 0);
            end else m_drain--;
         end
         m_cyc++;
      end
      m_err |= hit;
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", tag, act, want);
      end
   endtask

   task automatic compare_all(input string tag);
      ent_t hd;
      if (mq.size() > 0) hd = mq[0];
      else hd = '{0, 0, '0, '0};
      chk({tag, ".log_valid"}, log_valid, mq.size() > 0);
      chk({tag, ".log_ch"},    log_ch,    hd.ch);
      chk({tag, ".log_cycle"}, log_cycle, hd.cyc);
      chk({tag, ".log_dut"},   log_dut,   hd.d);
      chk({tag, ".log_exp"},   log_exp,   hd.e);
      chk({tag, ".log_ovf"},   log_ovf,   m_ovf);
      chk({tag, ".err_mask"},  err_mask,  m_err);
      chk({tag, ".hlt_err"},   hlt_err,   m_herr);
      chk({tag, ".timeout"},   timeout,   m_tmo);
      chk({tag, ".done"},      done,      m_fin);
      chk({tag, ".pass"},      pass,      m_fin && m_pass);
   endtask

   function automatic logic [DW-1:0] rnd_word();
      logic [DW-1:0] w;
      for (int i = 0; i < NUM_CH; i++) w[i*WIDTH +: WIDTH] = WIDTH'($urandom);
      return w;
   endfunction

   // called at a negedge; drives one cycle, advances the model, checks after the edge
   task automatic step(input string tag, input logic st, input logic [NUM_CH-1:0] v,
                       input logic [DW-1:0] d, input logic [DW-1:0] e,
                       input logic h, input logic eh, input logic rd);
      stall = st; ch_valid = v; dut_data = d; exp_data = e;
      hlt = h; exp_hlt = eh; log_rd = rd;
      model_step(st, v, d, e, h, eh, rd);
      @(posedge clk);
      @(negedge clk);
      compare_all(tag);
   endtask

   task automatic quiet(input string tag, input logic h, input logic eh, input logic rd);
      logic [DW-1:0] d;
      d = rnd_word();
      step(tag, 1'b0, '1, d, d, h, eh, rd);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      stall = 1'($urandom); ch_valid = NUM_CH'($urandom);
      dut_data = rnd_word(); exp_data = rnd_word();
      hlt = 1'($urandom); exp_hlt = 1'($urandom); log_rd = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      compare_all("reset");
   endtask

   task automatic mis_word(input int ch, output logic [DW-1:0] d, output logic [DW-1:0] e);
      d = rnd_word();
      e = d;
      e[ch*WIDTH +: WIDTH] = ~d[ch*WIDTH +: WIDTH];
   endtask

   initial begin
      logic [DW-1:0] d, e;
      int n;
      @(negedge clk);
      do_reset();

      // 1: clean run, halt at cycle 20, PASS after the drain window
      for (int c = 0; c < 20; c++) quiet("t1_run", 0, 0, 0);
      quiet("t1_hlt", 1, 1, 0);
      for (int k = 0; k < DRAIN_CYC; k++) quiet("t1_drain", 1'($urandom), 1'($urandom), 0);
      chk("t1_done", done, 1);
      chk("t1_pass", pass, 1);
      chk("t1_log_valid", log_valid, 0);
      chk("t1_err_mask", err_mask, 0);

      // 2: ch2 mismatch at cycle 7
      do_reset();
      for (int c = 0; c < 7; c++) quiet("t2_run", 0, 0, 0);
      d = rnd_word(); e = d;
      d[2*WIDTH +: WIDTH] = 16'h1234;
      e[2*WIDTH +: WIDTH] = 16'h1235;
      step("t2_mis", 0, '1, d, e, 0, 0, 0);
      chk("t2_log_valid", log_valid, 1);
      chk("t2_log_ch", log_ch, 2);
      chk("t2_log_cycle", log_cycle, 7);
      chk("t2_log_dut", log_dut, 16'h1234);
      chk("t2_err_mask", err_mask, 5'b00100);
      quiet("t2_hlt", 1, 1, 0);
      for (int k = 0; k < DRAIN_CYC; k++) quiet("t2_drain", 0, 0, 0);
      chk("t2_done", done, 1);
      chk("t2_pass", pass, 0);

      // 3: ch1 and ch3 together -> single entry for ch1
      do_reset();
      for (int c = 0; c < 3; c++) quiet("t3_run", 0, 0, 0);
      d = rnd_word(); e = d;
      e[1*WIDTH +: WIDTH] = ~d[1*WIDTH +: WIDTH];
      e[3*WIDTH +: WIDTH] = ~d[3*WIDTH +: WIDTH];
      step("t3_mis", 0, '1, d, e, 0, 0, 0);
      chk("t3_log_ch", log_ch, 1);
      chk("t3_err_mask", err_mask, 5'b01010);
      quiet("t3_pop", 0, 0, 1);
      chk("t3_one_entry", log_valid, 0);

      // 4: overflow, then full log with a simultaneous pop
      do_reset();
      for (int k = 0; k < 9; k++) begin mis_word(0, d, e); step("t4_fill", 0, '1, d, e, 0, 0, 0); end
      chk("t4_ovf", log_ovf, 1);
      for (int k = 0; k < LOG_DEPTH; k++) quiet("t4_drainlog", 0, 0, 1);
      chk("t4_empty", log_valid, 0);
      do_reset();
      for (int k = 0; k < 8; k++) begin mis_word(0, d, e); step("t4b_fill", 0, '1, d, e, 0, 0, 0); end
      mis_word(0, d, e);
      step("t4b_poppush", 0, '1, d, e, 0, 0, 1);
      chk("t4b_ovf", log_ovf, 0);
      chk("t4b_head_cycle", log_cycle, 1);

      // 5: stall suppresses compare; halt disagreement fails
      do_reset();
      d = rnd_word(); e = ~d;
      step("t5_stall", 1, '1, d, e, 0, 0, 0);
      chk("t5_err_mask", err_mask, 0);
      chk("t5_log_valid", log_valid, 0);
      quiet("t5_hlt", 1, 0, 0);
      chk("t5_done", done, 1);
      chk("t5_hlt_err", hlt_err, 1);
      chk("t5_pass", pass, 0);
      mis_word(4, d, e);
      step("t5_nocompare", 0, '1, d, e, 0, 0, 0);

      // 6: timeout, then reset in the middle of DRAIN
      do_reset();
      n = 0;
      while (!done && n < TIMEOUT + 10) begin quiet("t6_run", 0, 0, 0); n++; end
      chk("t6_timeout", timeout, 1);
      chk("t6_done", done, 1);
      chk("t6_pass", pass, 0);
      chk("t6_cycles", n, TIMEOUT);
      do_reset();
      quiet("t6b_run", 0, 0, 0);
      mis_word(3, d, e);
      step("t6b_mis", 0, '1, d, e, 0, 0, 0);
      quiet("t6b_hlt", 1, 1, 0);
      quiet("t6b_drain", 0, 0, 0);
      do_reset();
      chk("t6b_err_mask", err_mask, 0);
      chk("t6b_log_valid", log_valid, 0);
      chk("t6b_done", done, 0);

      // randomized runs: halt style, mismatch rate and pop rate vary per run
      for (int r = 0; r < 10; r++) begin
         int hcyc, kind, rdp;
         logic h, eh, rd, st;
         logic [NUM_CH-1:0] v;
         do_reset();
         hcyc = $urandom_range(5, 55);
         kind = $urandom_range(0, 2);
         rdp  = $urandom_range(0, 3);
         for (int c = 0; c < 70; c++) begin
            st = ($urandom_range(0, 5) == 0);
            v  = NUM_CH'($urandom);
            d  = rnd_word(); e = d;
            for (int i = 0; i < NUM_CH; i++)
               if ($urandom_range(0, 9) == 0) e[i*WIDTH +: WIDTH] = d[i*WIDTH +: WIDTH] ^ WIDTH'($urandom_range(1, 65535));
            rd = ($urandom_range(0, 3) < rdp);
            h = 0; eh = 0;
            if (c >= hcyc) begin
               if (kind == 0) begin h = 1; eh = 1; end
               else if (kind == 1) begin h = 1'($urandom); eh = ~h; end
            end
            step("rand", st, v, d, e, h, eh, rd);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
